// File: rtl/int_ctrl.sv
// int_ctrl: external interrupt controller for the ID/EX int_detect/int_type inputs.
// Synchronises irq lines, latches rising edges as pending, masks, applies fixed
// priority (line 0 highest) and presents one request until ack, then tracks it
// in service until end-of-interrupt.
// Ports: clk, reset (sync, active-high); irq[IRQ_NUM] async requests; int_en
// global enable; int_ack / int_eoi pipeline handshakes; cfg_we/cfg_addr/
// cfg_wdata/cfg_rdata register port (0=MASK, 1=PEND W1C, 2=STAT);
// int_detect / int_type / int_id request outputs.
// Optional: define INT_CTRL_NEST_EN for one level of higher-priority nesting.
module int_ctrl #(
    parameter int               IRQ_NUM  = 8,
    parameter int               EXP_W    = 3,
    parameter logic [EXP_W-1:0] INT_CODE = EXP_W'(1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IRQ_NUM-1:0] irq,
    input  logic               int_en,
    input  logic               int_ack,
    input  logic               int_eoi,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic [15:0]        cfg_rdata,
    output logic               int_detect,
    output logic [EXP_W-1:0]   int_type,
    output logic [3:0]         int_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } state_t;

    logic [IRQ_NUM-1:0] r_s1, r_s2, r_s3;
    logic [IRQ_NUM-1:0] r_pend, r_mask;
    state_t             r_state;
    logic               r_det;
    logic [3:0]         r_id;
    logic [15:0]        r_rdata;
    logic               w_nv;

`ifdef INT_CTRL_NEST_EN
    logic [3:0]         r_sav;
    logic               r_nv;
    assign w_nv = r_nv;
`else
    assign w_nv = 1'b0;
`endif

    logic [IRQ_NUM-1:0] w_edge, w_req, w_id_oh, w_wd;
    logic [IRQ_NUM-1:0] w_mask_n, w_pend_n, w_w1c, w_ackclr;
    logic               w_mask_wr, w_pend_wr, w_ack, w_revoke;
    logic [3:0]         w_win;
    logic [15:0]        w_stat, w_rd;
    logic               w_unused;

    // Upper write-data bits are architecturally ignored.
    assign w_unused  = &{1'b0, cfg_wdata};

    assign w_edge    = r_s2 & ~r_s3;
    assign w_req     = r_pend & r_mask;
    assign w_id_oh   = IRQ_NUM'(1) << r_id;
    assign w_wd      = cfg_wdata[IRQ_NUM-1:0];
    assign w_mask_wr = cfg_we && (cfg_addr == 2'd0);
    assign w_pend_wr = cfg_we && (cfg_addr == 2'd1);
    assign w_ack     = (r_state == S_REQ) && int_ack;
    assign w_w1c     = w_pend_wr ? w_wd : '0;
    assign w_ackclr  = w_ack ? w_id_oh : '0;
    assign w_mask_n  = w_mask_wr ? w_wd : r_mask;

    // New edges are OR-ed in last so a same-cycle set beats W1C or ack clear.
    assign w_pend_n  = (r_pend & ~w_w1c & ~w_ackclr) | w_edge;

    // Revoke looks at next-cycle mask/pend so a write drops the request at once.
    assign w_revoke  = !int_en || !(|(w_mask_n & w_pend_n & w_id_oh));

    always_comb begin
        w_win = 4'd0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (w_req[i]) w_win = 4'(i);
        end
    end

    assign w_stat = {7'd0, w_nv, r_id, 2'd0,
                     r_state == S_SERV, r_state == S_REQ};

    always_comb begin
        w_rd = 16'd0;
        case (cfg_addr)
            2'd0:    w_rd = 16'(r_mask);
            2'd1:    w_rd = 16'(r_pend);
            2'd2:    w_rd = w_stat;
            default: w_rd = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_rdata <= 16'd0;
            r_state <= S_IDLE;
            r_det   <= 1'b0;
            r_id    <= 4'd0;
`ifdef INT_CTRL_NEST_EN
            r_sav   <= 4'd0;
            r_nv    <= 1'b0;
`endif
        end else begin
            r_s1    <= irq;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pend  <= w_pend_n;
            r_mask  <= w_mask_n;
            r_rdata <= w_rd;
            unique case (r_state)
                S_IDLE: begin
                    if (int_en && |w_req) begin
                        r_state <= S_REQ;
                        r_det   <= 1'b1;
                        r_id    <= w_win;
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        r_state <= S_SERV;
                        r_det   <= 1'b0;
                    end else if (w_revoke) begin
                        r_det <= 1'b0;
`ifdef INT_CTRL_NEST_EN
                        // A revoked nested request falls back to the saved one.
                        if (r_nv) begin
                            r_state <= S_SERV;
                            r_id    <= r_sav;
                            r_nv    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_id    <= 4'd0;
                        end
`else
                        r_state <= S_IDLE;
                        r_id    <= 4'd0;
`endif
                    end
                end
                S_SERV: begin
                    if (int_eoi) begin
`ifdef INT_CTRL_NEST_EN
                        if (r_nv) begin
                            r_id <= r_sav;
                            r_nv <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end
`ifdef INT_CTRL_NEST_EN
                    else if (!r_nv && int_en && |w_req && (w_win < r_id)) begin
                        r_state <= S_REQ;
                        r_det   <= 1'b1;
                        r_sav   <= r_id;
                        r_nv    <= 1'b1;
                        r_id    <= w_win;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_det   <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_rdata  = r_rdata;
    assign int_detect = r_det;
    assign int_type   = r_det ? INT_CODE : '0;
    assign int_id     = r_id;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vector table plus hand sequences for int_ctrl.
// Inputs change 1 time unit after posedge; outputs are sampled at that point.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq;
    logic        int_en, int_ack, int_eoi;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        int_detect;
    logic [2:0]  int_type;
    logic [3:0]  int_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_ctrl #(.IRQ_NUM(8), .EXP_W(3), .INT_CODE(3'h1)) dut (
        .clk(clk), .reset(reset), .irq(irq), .int_en(int_en),
        .int_ack(int_ack), .int_eoi(int_eoi), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .int_detect(int_detect), .int_type(int_type), .int_id(int_id)
    );

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wd;
        logic [7:0]  irq;
        logic        ack;
        logic        eoi;
        logic        det;
        logic [3:0]  id;
        logic        cr;
        logic [15:0] rd;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic we, input logic [1:0] a,
                       input logic [15:0] wd, input logic [7:0] ir,
                       input logic ack, input logic eoi,
                       input logic det, input logic [3:0] id,
                       input logic cr, input logic [15:0] rd);
        vec_t v;
        v.we = we; v.addr = a; v.wd = wd; v.irq = ir;
        v.ack = ack; v.eoi = eoi; v.det = det; v.id = id;
        v.cr = cr; v.rd = rd;
        tv.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [1:0] a,
                         input logic [15:0] wd, input logic [7:0] ir,
                         input logic ack, input logic eoi);
        cfg_we = we; cfg_addr = a; cfg_wdata = wd; irq = ir;
        int_ack = ack; int_eoi = eoi;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic det,
                           input logic [3:0] id);
        chk({nm, ".det"}, 16'(int_detect), 16'(det));
        chk({nm, ".type"}, 16'(int_type), det ? 16'h1 : 16'h0);
        chk({nm, ".id"}, 16'(int_id), 16'(id));
    endtask

    initial begin
        reset = 1'b1;
        int_en = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_out("reset", 0, 0);
        chk("reset.rdata", cfg_rdata, 16'h0);
        reset = 1'b0;
        int_en = 1'b1;

        // T1: single line, 4-cycle latency, ack, eoi
        add(1, 0, 16'h01, 8'h00, 0, 0, 0, 0, 1, 16'h0000);
        add(0, 0, 0, 8'h01, 0, 0, 0, 0, 1, 16'h0001);
        add(0, 0, 0, 8'h01, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 8'h01, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8'h01, 0, 0, 1, 0, 1, 16'h0001);
        add(0, 2, 0, 8'h01, 0, 0, 1, 0, 1, 16'h0001);
        add(0, 2, 0, 8'h01, 1, 0, 0, 0, 1, 16'h0001);
        add(0, 2, 0, 8'h01, 0, 0, 0, 0, 1, 16'h0002);
        add(0, 1, 0, 8'h01, 0, 1, 0, 0, 1, 16'h0000);
        add(0, 2, 0, 8'h00, 0, 0, 0, 0, 1, 16'h0000);
        // T2: simultaneous edges on 5 and 2
        add(1, 0, 16'hFF, 8'h00, 0, 0, 0, 0, 1, 16'h0001);
        add(0, 0, 0, 8'h24, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 8'h24, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 8'h24, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 8'h24, 0, 0, 1, 2, 0, 0);
        add(0, 0, 0, 8'h24, 1, 0, 0, 2, 0, 0);
        add(0, 1, 0, 8'h24, 0, 0, 0, 2, 1, 16'h0020);
        add(0, 0, 0, 8'h24, 0, 1, 0, 2, 0, 0);
        add(0, 0, 0, 8'h24, 0, 0, 1, 5, 0, 0);
        add(0, 0, 0, 8'h24, 1, 0, 0, 5, 0, 0);
        add(0, 0, 0, 8'h24, 0, 1, 0, 5, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 5, 0, 0);
        // T3: no re-arbitration while presented
        add(0, 0, 0, 8'h08, 0, 0, 0, 5, 0, 0);
        add(0, 0, 0, 8'h08, 0, 0, 0, 5, 0, 0);
        add(0, 0, 0, 8'h08, 0, 0, 0, 5, 0, 0);
        add(0, 0, 0, 8'h08, 0, 0, 1, 3, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, 8'h0A, 0, 0, 1, 3, 0, 0);
        add(0, 1, 0, 8'h0A, 1, 0, 0, 3, 1, 16'h000A);
        add(0, 0, 0, 8'h0A, 0, 1, 0, 3, 0, 0);
        add(0, 0, 0, 8'h0A, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 8'h0A, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 8'h0A, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
        // T4: revoke by masking, pending survives, W1C clears
        add(0, 0, 0, 8'h10, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 8'h10, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 8'h10, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 8'h10, 0, 0, 1, 4, 0, 0);
        add(1, 0, 16'h00, 8'h10, 0, 0, 0, 0, 1, 16'h00FF);
        add(0, 2, 0, 8'h10, 0, 0, 0, 0, 1, 16'h0000);
        add(0, 1, 0, 8'h10, 0, 0, 0, 0, 1, 16'h0010);
        add(1, 1, 16'h10, 8'h10, 0, 0, 0, 0, 1, 16'h0010);
        add(0, 1, 0, 8'h10, 0, 0, 0, 0, 1, 16'h0000);
        // T5: edge and W1C on the same bit in the same cycle
        add(0, 1, 0, 8'h50, 0, 0, 0, 0, 1, 16'h0000);
        add(0, 1, 0, 8'h50, 0, 0, 0, 0, 1, 16'h0000);
        add(1, 1, 16'h40, 8'h50, 0, 0, 0, 0, 1, 16'h0000);
        add(0, 1, 0, 8'h50, 0, 0, 0, 0, 1, 16'h0040);
        add(1, 1, 16'h40, 8'h50, 0, 0, 0, 0, 1, 16'h0040);
        add(0, 1, 0, 8'h50, 0, 0, 0, 0, 1, 16'h0000);
        add(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 16'h0000);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].we, tv[i].addr, tv[i].wd, tv[i].irq,
                  tv[i].ack, tv[i].eoi);
            tick();
            chk_out($sformatf("vec%0d", i), tv[i].det, tv[i].id);
            if (tv[i].cr)
                chk($sformatf("vec%0d.rdata", i), cfg_rdata, tv[i].rd);
        end

        // T6: higher-priority edge while servicing id=5
        drive(1, 0, 16'hFF, 8'h00, 0, 0); tick();
        drive(0, 0, 0, 8'h20, 0, 0); tick(); tick(); tick();
        tick();
        chk_out("t6.req5", 1, 5);
        drive(0, 0, 0, 8'h20, 1, 0); tick();
        chk_out("t6.ack5", 0, 5);
        drive(0, 0, 0, 8'h22, 0, 0); tick(); tick(); tick();
        tick();
`ifdef INT_CTRL_NEST_EN
        chk_out("t6.nest1", 1, 1);
        drive(0, 2, 0, 8'h22, 0, 0); tick();
        chk("t6.stat_nest", cfg_rdata, 16'h0111);
        drive(0, 0, 0, 8'h22, 1, 0); tick();
        chk_out("t6.ack1", 0, 1);
        drive(0, 0, 0, 8'h22, 0, 1); tick();
        chk_out("t6.pop5", 0, 5);
        drive(0, 2, 0, 8'h22, 0, 0); tick();
        chk("t6.stat_serv5", cfg_rdata, 16'h0052);
        drive(0, 0, 0, 8'h22, 0, 1); tick();
        drive(0, 2, 0, 8'h22, 0, 0); tick();
        chk("t6.stat_idle", cfg_rdata, 16'h0050);
        chk_out("t6.idle", 0, 5);
`else
        chk_out("t6.wait", 0, 5);
        drive(0, 2, 0, 8'h22, 0, 0); tick();
        chk("t6.stat_serv5", cfg_rdata, 16'h0052);
        drive(0, 0, 0, 8'h22, 0, 1); tick();
        chk_out("t6.eoi5", 0, 5);
        drive(0, 0, 0, 8'h22, 0, 0); tick();
        chk_out("t6.req1", 1, 1);
        drive(0, 0, 0, 8'h22, 1, 0); tick();
        chk_out("t6.ack1", 0, 1);
        drive(0, 0, 0, 8'h22, 0, 1); tick();
`endif
        drive(0, 0, 0, 8'h00, 0, 0); tick();

        // int_en low blocks presentation; raising it releases the request
        int_en = 1'b0;
        drive(0, 0, 0, 8'h80, 0, 0); tick(); tick(); tick(); tick();
        tick();
        chk_out("en0.block", 0, int_id);
        int_en = 1'b1;
        tick();
        chk_out("en1.req7", 1, 7);
        int_en = 1'b0;
        tick();
        chk_out("en0.revoke", 0, 0);
        int_en = 1'b1;
        drive(1, 1, 16'h80, 8'h80, 0, 0); tick();
        drive(0, 0, 0, 8'h00, 0, 0); tick();

        // Reset while a request is presented
        drive(0, 0, 0, 8'h01, 0, 0); tick(); tick(); tick(); tick();
        chk_out("rst.pre", 1, 0);
        drive(0, 0, 0, 8'h00, 0, 0);
        reset = 1'b1;
        tick(); tick();
        chk_out("rst.mid", 0, 0);
        chk("rst.rdata", cfg_rdata, 16'h0);
        reset = 1'b0;
        drive(0, 1, 0, 8'h00, 0, 0); tick();
        chk("rst.pend", cfg_rdata, 16'h0);
        drive(0, 0, 0, 8'h00, 0, 0); tick();
        chk("rst.mask", cfg_rdata, 16'h0);
        tick(); tick();
        chk_out("rst.post", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
